// File: rtl/alu_seq.sv
// Command sequencer for an external combinational ALU: 8x32 register file, IDLE->EXEC->RESP, response 2 cycles after accept, held until rsp_ready.
// Optional ALU_SEQ_R0_ZERO_EN makes R0 read as zero and discards writes to it.
module alu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLTU = 3'd5,
    OP_LI   = 3'd6,
    OP_RSVD = 3'd7
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [3:0]  rsvd;
    logic [15:0] imm;
  } cmd_t;

  state_t      state, state_nxt;
  cmd_t        cmd;
  op_t         op_q;
  logic [2:0]  rd_q;
  logic [15:0] imm_q;
  logic [31:0] rf [8];
  logic [31:0] rs1_val, rs2_val, wr_data;
  logic        wr_en, accept, is_alu_op;
  logic        unused_bits;

  assign cmd         = cmd_t'(cmd_data);
  assign unused_bits = ^cmd.rsvd;
  assign accept      = cmd_valid && cmd_ready;
  assign is_alu_op   = (cmd.op != OP_LI) && (cmd.op != OP_RSVD);

  function automatic logic [2:0] sel_map(input op_t op);
    case (op)
      OP_ADD:  return 3'b100;
      OP_SUB:  return 3'b101;
      OP_AND:  return 3'b110;
      OP_OR:   return 3'b111;
      OP_XOR:  return 3'b000;
      OP_SLTU: return 3'b001;
      default: return 3'b100;
    endcase
  endfunction

  // Operands are sampled at accept time, so an rd==rs write in EXEC cannot alias them.
  always_comb begin
    rs1_val = rf[cmd.rs1];
    rs2_val = rf[cmd.rs2];
`ifdef ALU_SEQ_R0_ZERO_EN
    if (cmd.rs1 == 3'd0) rs1_val = '0;
    if (cmd.rs2 == 3'd0) rs2_val = '0;
`endif
  end

  always_comb begin
    wr_en   = (state == S_EXEC) && (op_q != OP_RSVD);
`ifdef ALU_SEQ_R0_ZERO_EN
    if (rd_q == 3'd0) wr_en = 1'b0;
`endif
    wr_data = (op_q == OP_LI) ? {16'h0000, imm_q} : alu_result;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid) state_nxt = S_EXEC;
      end
      S_EXEC: state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      imm_q    <= '0;
      alu_op1  <= '0;
      alu_op2  <= '0;
      alu_sel  <= 3'b100;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q  <= cmd.op;
        rd_q  <= cmd.rd;
        imm_q <= cmd.imm;
        // LI and the reserved op leave the ALU inputs untouched.
        if (is_alu_op) begin
          alu_op1 <= rs1_val;
          alu_op2 <= rs2_val;
          alu_sel <= sel_map(cmd.op);
        end
      end
      if (state == S_EXEC) begin
        case (op_q)
          OP_LI: begin
            rsp_data <= {16'h0000, imm_q};
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
          end
          OP_RSVD: begin
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b1;
          end
          default: begin
            rsp_data <= alu_result;
            rsp_zero <= alu_zero;
            rsp_err  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[rd_q] <= wr_data;
    end
  end

  rsp_hold_a: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_zero) && $stable(rsp_err)));

  no_overlap_a: assert property (@(posedge clk) !(cmd_ready && rsp_valid));

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU, spec-derived vector table, hand-written stall/reset/R0 sequences, random commands against a register-file model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_zero, rsp_err, alu_zero;
  logic [31:0] cmd_data, rsp_data, alu_op1, alu_op2, alu_result;
  logic [2:0]  alu_sel;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mrf [8];
  logic [2:0]  m_sel;
  logic [2:0]  sel_tab [6] = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b001};

  typedef struct {
    string       tag;
    logic [31:0] cmd;
    logic [31:0] d;
    logic        z;
    logic        e;
    logic        has_sel;
    logic [2:0]  sel;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always_comb begin
    case (alu_sel)
      3'b100:  alu_result = alu_op1 + alu_op2;
      3'b101:  alu_result = alu_op1 - alu_op2;
      3'b110:  alu_result = alu_op1 & alu_op2;
      3'b111:  alu_result = alu_op1 | alu_op2;
      3'b000:  alu_result = alu_op1 ^ alu_op2;
      3'b001:  alu_result = (alu_op1 < alu_op2) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_op1 == 32'd0) && (alu_op2 == 32'd0);
  end

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [15:0] imm);
    return {op, rd, rs1, rs2, 4'b0000, imm};
  endfunction

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [2:0] idx);
`ifdef ALU_SEQ_R0_ZERO_EN
    if (idx == 3'd0) return 32'd0;
`endif
    return mrf[idx];
  endfunction

  // Architectural model: one command in, expected response and EXEC-cycle selection out.
  task automatic model_step(input logic [31:0] w, output logic [31:0] d, output logic z,
                            output logic e, output logic [2:0] sel);
    logic [2:0]  op, rd;
    logic [31:0] a, b;
    logic        wr;
    op  = w[31:29];
    rd  = w[28:26];
    a   = mread(w[25:23]);
    b   = mread(w[22:20]);
    z   = 1'b0;
    e   = 1'b0;
    sel = m_sel;
    case (op)
      3'd0:    d = a + b;
      3'd1:    d = a - b;
      3'd2:    d = a & b;
      3'd3:    d = a | b;
      3'd4:    d = a ^ b;
      3'd5:    d = (a < b) ? 32'd1 : 32'd0;
      3'd6:    d = {16'h0000, w[15:0]};
      default: begin d = 32'd0; e = 1'b1; end
    endcase
    if (op <= 3'd5) begin
      z     = (a == 32'd0) && (b == 32'd0);
      sel   = sel_tab[op];
      m_sel = sel;
    end
    wr = (op != 3'd7);
`ifdef ALU_SEQ_R0_ZERO_EN
    if (rd == 3'd0) wr = 1'b0;
`endif
    if (wr) mrf[rd] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mrf[i] = 32'd0;
    m_sel = 3'b100;
  endtask

  // Entered and left on a falling edge with the DUT idle.
  task automatic run_cmd(input string tag, input logic [31:0] w, input int stall,
                         input logic [31:0] ed, input logic ez, input logic ee, input logic [2:0] es);
    int guard;
    int lat;
    cmd_data  = w;
    cmd_valid = 1'b1;
    rsp_ready = (stall == 0);
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk(tag, "cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk(tag, "exec_sel", 32'(alu_sel), 32'(es));
    chk(tag, "exec_cmd_ready", 32'(cmd_ready), 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, "rsp_valid_wait", 32'(rsp_valid), 32'd1);
    chk(tag, "latency", 32'(lat), 32'd2);
    chk(tag, "data", rsp_data, ed);
    chk(tag, "zero", 32'(rsp_zero), 32'(ez));
    chk(tag, "err", 32'(rsp_err), 32'(ee));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk(tag, "stall_valid", 32'(rsp_valid), 32'd1);
      chk(tag, "stall_data", rsp_data, ed);
      chk(tag, "stall_zero", 32'(rsp_zero), 32'(ez));
      chk(tag, "stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk(tag, "post_cmd_ready", 32'(cmd_ready), 32'd1);
    chk(tag, "post_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  task automatic exp_cmd(input string tag, input logic [31:0] w, input int stall,
                         input logic [31:0] ed, input logic ez, input logic ee);
    logic [31:0] md;
    logic        mz, me;
    logic [2:0]  ms;
    model_step(w, md, mz, me, ms);
    run_cmd(tag, w, stall, ed, ez, ee, ms);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w, md;
    logic        mz, me;
    logic [2:0]  ms;
    int          st;

    vecs[0]  = '{"li_r1",   mk(3'd6, 3'd1, 3'd0, 3'd0, 16'h0005), 32'd5, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[1]  = '{"li_r2",   mk(3'd6, 3'd2, 3'd0, 3'd0, 16'h0003), 32'd3, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[2]  = '{"add",     mk(3'd0, 3'd3, 3'd1, 3'd2, 16'h0),    32'd8, 1'b0, 1'b0, 1'b1, 3'b100};
    vecs[3]  = '{"sub",     mk(3'd1, 3'd4, 3'd1, 3'd2, 16'h0),    32'd2, 1'b0, 1'b0, 1'b1, 3'b101};
    vecs[4]  = '{"and",     mk(3'd2, 3'd4, 3'd1, 3'd2, 16'h0),    32'd1, 1'b0, 1'b0, 1'b1, 3'b110};
    vecs[5]  = '{"or",      mk(3'd3, 3'd4, 3'd1, 3'd2, 16'h0),    32'd7, 1'b0, 1'b0, 1'b1, 3'b111};
    vecs[6]  = '{"xor",     mk(3'd4, 3'd4, 3'd1, 3'd2, 16'h0),    32'd6, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[7]  = '{"sltu_lt", mk(3'd5, 3'd4, 3'd2, 3'd1, 16'h0),    32'd1, 1'b0, 1'b0, 1'b1, 3'b001};
    vecs[8]  = '{"sltu_ge", mk(3'd5, 3'd4, 3'd1, 3'd2, 16'h0),    32'd0, 1'b0, 1'b0, 1'b1, 3'b001};
    vecs[9]  = '{"add_zero",mk(3'd0, 3'd5, 3'd6, 3'd7, 16'h0),    32'd0, 1'b1, 1'b0, 1'b1, 3'b100};
    vecs[10] = '{"rsvd",    mk(3'd7, 3'd1, 3'd2, 3'd3, 16'hBEEF), 32'd0, 1'b0, 1'b1, 1'b0, 3'b000};
    vecs[11] = '{"rd_back", mk(3'd0, 3'd1, 3'd1, 3'd0, 16'h0),    32'd5, 1'b0, 1'b0, 1'b1, 3'b100};

    model_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset", "cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset", "rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset", "rsp_data", rsp_data, 32'd0);
    chk("reset", "alu_op1", alu_op1, 32'd0);
    chk("reset", "alu_sel", 32'(alu_sel), 32'b100);
    rst = 1'b0;
    @(negedge clk);
    chk("reset", "idle_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      model_step(vecs[i].cmd, md, mz, me, ms);
      run_cmd(vecs[i].tag, vecs[i].cmd, 0, vecs[i].d, vecs[i].z, vecs[i].e,
              vecs[i].has_sel ? vecs[i].sel : ms);
    end

    exp_cmd("stall", mk(3'd3, 3'd4, 3'd1, 3'd2, 16'h0), 5, 32'd7, 1'b0, 1'b0);

    // Reset while ADD r3 is in EXEC: it must never respond nor write r3.
    cmd_data = mk(3'd0, 3'd3, 3'd1, 3'd2, 16'h0);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst", "cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst", "rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst", "rsp_data", rsp_data, 32'd0);
    chk("mid_rst", "rsp_zero", 32'(rsp_zero), 32'd0);
    chk("mid_rst", "rsp_err", 32'(rsp_err), 32'd0);
    chk("mid_rst", "alu_op1", alu_op1, 32'd0);
    chk("mid_rst", "alu_op2", alu_op2, 32'd0);
    chk("mid_rst", "alu_sel", 32'(alu_sel), 32'b100);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst", "no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("mid_rst", "ready_after", 32'(cmd_ready), 32'd1);
    exp_cmd("r3_cleared", mk(3'd0, 3'd6, 3'd3, 3'd0, 16'h0), 0, 32'd0, 1'b1, 1'b0);

    exp_cmd("li_r0", mk(3'd6, 3'd0, 3'd0, 3'd0, 16'h1234), 0, 32'h0000_1234, 1'b0, 1'b0);
`ifdef ALU_SEQ_R0_ZERO_EN
    exp_cmd("add_r0", mk(3'd0, 3'd1, 3'd0, 3'd0, 16'h0), 0, 32'd0, 1'b1, 1'b0);
`else
    exp_cmd("add_r0", mk(3'd0, 3'd1, 3'd0, 3'd0, 16'h0), 0, 32'h0000_2468, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 200; i++) begin
      w  = $urandom;
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      model_step(w, md, mz, me, ms);
      run_cmd("rnd", w, st, md, mz, me, ms);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Command sequencer that drives the datapath's combinational ALU. It accepts 32-bit operation words over a valid/ready channel and decodes them to the ALU's 3-bit selection code. Operands come from an internal 8×32 register file. The sequencer presents them to the external ALU, captures result and zero, writes the result back, and returns it on a valid/ready response channel. It is the initiator side of the ALU's op1/op2/selection → result/zero interface.

## Interface
- No parameters; widths fixed (32-bit data, 8 registers, 3-bit selection).
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command word valid
- cmd_ready  out  1  sequencer can accept a command
- cmd_data  in  32  operation word, fields below
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  result written to rd
- rsp_zero  out  1  captured ALU zero flag
- rsp_err  out  1  reserved opcode was received
- alu_op1  out  32  ALU operand 1 (registered)
- alu_op2  out  32  ALU operand 2 (registered)
- alu_sel  out  3  ALU selection (registered)
- alu_result  in  32  ALU result (combinational from alu_op*/alu_sel)
- alu_zero  in  1  ALU zero (set only when op1 == 0 and op2 == 0)

## Operation
- Command fields: [31:29] op, [28:26] rd, [25:23] rs1, [22:20] rs2, [15:0] imm, others ignored.
- op → alu_sel: 0 ADD→3'b100, 1 SUB→3'b101, 2 AND→3'b110, 3 OR→3'b111, 4 XOR→3'b000, 5 SLTU→3'b001.
- 6 LI: rd ← {16'h0, imm}; no ALU use; alu_* outputs hold their previous values.
- 7: reserved; no register write; rsp_err=1, rsp_data=0, rsp_zero=0.
- FSM IDLE → EXEC → RESP → IDLE.
  - IDLE: cmd_ready=1. On cmd_valid, latch the command and load alu_op1=R[rs1], alu_op2=R[rs2], alu_sel=mapped code.
  - EXEC: for ALU ops, capture alu_result into rsp_data and R[rd], and alu_zero into rsp_zero. For LI, rsp_data = zero-extended imm and rsp_zero=0.
  - RESP: rsp_valid=1; hold all rsp_* stable until rsp_ready; on handshake → IDLE.
- Arithmetic is done by the ALU; the sequencer neither modifies nor sign-extends results. SLTU result is 0 or 1.
- rd == rs1/rs2 is allowed. Operands are read before the write, and the write is visible to the next command.
- Reset values: cmd_ready=0 during reset cycle, then 1 in IDLE. rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0, alu_op1=0, alu_op2=0, alu_sel=3'b100, all registers 0, state IDLE.

## Timing
- Command accepted at edge T → rsp_valid high from T+2; minimum 3 cycles per command (back-to-back when rsp_ready is held high).
- cmd_ready is low in EXEC and RESP; no command overlap.
- RESP with rsp_ready=1 in the first cycle → IDLE next cycle, cmd_ready=1 then.
- rsp_ready stall: remain in RESP indefinitely with outputs unchanged.
- rst in any state: next cycle IDLE, rsp_valid=0, register file cleared; an in-flight command is dropped without write-back.

## Configuration
- ALU_SEQ_R0_ZERO_EN defined: R0 always reads 0 and writes to rd=0 are discarded. rsp_data still reports the computed value.
- Undefined: R0 is an ordinary writable register.

## Test plan
- Reset, then LI r1,0x0005; LI r2,0x0003; ADD r3,r1,r2 → rsp_data=8, rsp_zero=0, alu_sel=3'b100 during EXEC, rsp_valid exactly 2 cycles after acceptance.
- With r1=5, r2=3: SUB → 2; AND → 1; OR → 7; XOR → 6; SLTU r4,r2,r1 → 1; SLTU r4,r1,r2 → 0.
- ADD r5,r6,r7 with r6=r7=0 → rsp_zero=1, rsp_data=0. Op 7 → rsp_err=1, rsp_data=0, no register changed (verify by reading back with ADD rX,rX,r0-equivalent).
- Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_data stable, cmd_ready=0; release → cmd_ready=1 the following cycle.
- Assert rst in EXEC of ADD r3 → no response, r3 reads 0 afterwards; all outputs at reset values.
- LI r0,0x1234 then ADD r1,r0,r0: with ALU_SEQ_R0_ZERO_EN → result 0; without the macro → 0x2468.
